// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide unit owning HI/LO; the result is computed at start and committed
// when the fixed-length busy window expires. States: IDLE (accepting ops) | MUL, DIV (window running).
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      res_hi_q, res_hi_d;
  logic [31:0]      res_lo_q, res_lo_d;
  logic             commit_q, commit_d;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] b_nz;
  logic signed [31:0] quo_s, rem_s;
  logic        [31:0] quo_u, rem_u;
  logic               div_ovf;

  // A zero divisor is replaced by 1 so the dividers never see it; the commit flag discards the result.
  always_comb begin
    prod_s  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u  = {32'd0, a} * {32'd0, b};
    b_nz    = (b != 32'd0) ? b : 32'd1;
    div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    quo_s   = $signed(a) / $signed(b_nz);
    rem_s   = $signed(a) % $signed(b_nz);
    quo_u   = a / b_nz;
    rem_u   = a % b_nz;
    if (div_ovf) begin
      quo_s = 32'sh8000_0000;
      rem_s = 32'sd0;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    commit_d = commit_q;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          case (md_op)
            OP_MULT: begin
              {res_hi_d, res_lo_d} = prod_s;
              commit_d = 1'b1;
              cnt_d    = CNT_W'(MULT_CYCLES - 1);
              state_d  = S_MUL;
            end
            OP_MULTU: begin
              {res_hi_d, res_lo_d} = prod_u;
              commit_d = 1'b1;
              cnt_d    = CNT_W'(MULT_CYCLES - 1);
              state_d  = S_MUL;
            end
            OP_DIV: begin
              res_hi_d = rem_s;
              res_lo_d = quo_s;
              commit_d = (b != 32'd0);
              cnt_d    = CNT_W'(DIV_CYCLES - 1);
              state_d  = S_DIV;
            end
            OP_DIVU: begin
              res_hi_d = rem_u;
              res_lo_d = quo_u;
              commit_d = (b != 32'd0);
              cnt_d    = CNT_W'(DIV_CYCLES - 1);
              state_d  = S_DIV;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
        S_MUL, S_DIV: begin
          if (cnt_q == '0) begin
            if (commit_q) begin
              hi_d = res_hi_q;
              lo_d = res_lo_q;
            end
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      commit_q <= commit_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomised bench for mdu_ctrl against an arithmetic reference model of HI/LO and window lengths.
module tb_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  md_op;
  logic [31:0] a, b;
  logic        flush;
  logic        busy;
  logic [31:0] hi, lo;

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0] m_hi, m_lo;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md_op (md_op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: signed division done on magnitudes, then signs applied (quotient toward zero,
  // remainder follows the dividend).
  function automatic void model(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb);
    longint      sa, sb, ua, ub, q, r, p;
    logic [63:0] pu;
    case (op)
      3'd1: begin
        p = longint'($signed(va)) * longint'($signed(vb));
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      3'd2: begin
        pu = {32'd0, va} * {32'd0, vb};
        m_hi = pu[63:32];
        m_lo = pu[31:0];
      end
      3'd3: if (vb != 0) begin
        sa = longint'($signed(va));
        sb = longint'($signed(vb));
        ua = (sa < 0) ? -sa : sa;
        ub = (sb < 0) ? -sb : sb;
        q = ua / ub;
        r = ua % ub;
        if ((sa < 0) != (sb < 0)) q = -q;
        if (sa < 0) r = -r;
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
      3'd4: if (vb != 0) begin
        m_lo = va / vb;
        m_hi = va % vb;
      end
      3'd5: m_hi = va;
      3'd6: m_lo = va;
      default: ;
    endcase
  endfunction

  // Presents one op at a negedge; flush_at = k > 0 raises flush during the k-th busy cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb,
                        input int flush_at, input bit flush_with_op);
    int n, exp_n;
    logic [31:0] old_hi, old_lo;
    old_hi = m_hi;
    old_lo = m_lo;
    md_op = op; a = va; b = vb; flush = flush_with_op;
    @(negedge clk);
    md_op = 3'd0; flush = 1'b0; a = $urandom; b = $urandom;
    exp_n = (op >= 3'd1 && op <= 3'd2) ? MC : (op >= 3'd3 && op <= 3'd4) ? DC : 0;
    if (flush_with_op) exp_n = 0;
    else if (flush_at > 0 && exp_n > 0) exp_n = flush_at;
    n = 0;
    while (busy && n < 60) begin
      n++;
      check_val("hi_hold", {32'd0, hi}, {32'd0, old_hi});
      check_val("lo_hold", {32'd0, lo}, {32'd0, old_lo});
      if (n == flush_at) flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
    end
    check_val($sformatf("busy_len op%0d", op), 64'(n), 64'(exp_n));
    if (!flush_with_op && !(flush_at > 0 && op >= 3'd1 && op <= 3'd4)) model(op, va, vb);
    check_val($sformatf("hi op%0d", op), {32'd0, hi}, {32'd0, m_hi});
    check_val($sformatf("lo op%0d", op), {32'd0, lo}, {32'd0, m_lo});
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] ra, rb;
    int          fa, nmax;
    bit          fw;
    rst_n = 1'b0; md_op = 3'd0; a = '0; b = '0; flush = 1'b0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    check_val("rst_hi", {32'd0, hi}, 64'd0);
    check_val("rst_lo", {32'd0, lo}, 64'd0);

    run_op(3'd1, 32'hFFFF_FFFD, 32'd5, 0, 0);
    check_val("mult_neg_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
    check_val("mult_neg_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFF1);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 0, 0);
    run_op(3'd4, 32'd7, 32'd2, 0, 0);
    check_val("divu_lo", {32'd0, lo}, 64'd3);
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 0, 0);
    check_val("div_neg_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFD);
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    check_val("div_ovf_lo", {32'd0, lo}, 64'h0000_0000_8000_0000);
    run_op(3'd5, 32'h1234_5678, 32'd0, 0, 0);
    run_op(3'd6, 32'h9ABC_DEF0, 32'd0, 0, 0);
    run_op(3'd3, 32'd100, 32'd0, 0, 0);
    check_val("div0_hi", {32'd0, hi}, 64'h0000_0000_1234_5678);
    run_op(3'd1, 32'd9, 32'd9, 3, 0);
    run_op(3'd6, 32'hDEAD_BEEF, 32'd0, 0, 1);
    check_val("flush_mtlo_lo", {32'd0, lo}, 64'h0000_0000_9ABC_DEF0);

    md_op = 3'd3; a = 32'd50; b = 32'd7;
    @(negedge clk);
    md_op = 3'd0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_busy", {63'd0, busy}, 64'd0);
    check_val("arst_hi", {32'd0, hi}, 64'd0);
    check_val("arst_lo", {32'd0, lo}, 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(3'd1, 32'd3, 32'd4, 0, 0);
    check_val("mult34_lo", {32'd0, lo}, 64'd12);

    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 9));
        3: rb = -32'($urandom_range(1, 9));
        default: ;
      endcase
      nmax = (op == 3'd1 || op == 3'd2) ? MC : DC;
      fa = ($urandom_range(0, 4) == 0) ? $urandom_range(1, nmax) : 0;
      fw = ($urandom_range(0, 9) == 0);
      run_op(op, ra, rb, fa, fw);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
